// File: rtl/ecc_check_log_pkg.sv
// ecc_pkg: shared constants, code-geometry helpers and the log entry type for
// the SECDED read-check pipeline (ecc_check_log).
//   ecc_data_pos(idx)   data bit index -> codeword position (1-based)
//   ecc_pos_data(pos)   codeword position -> data bit index, -1 for check slots
//   ecc_mask(i, dw)     data bits covered by Hamming check bit i
//   ecc_chk(data)       full check-bit vector, overall parity in bit cw-1
// Helpers work on ECC_MAX_DW/ECC_MAX_CW wide vectors so one package serves
// every parameterisation; callers pass the real widths.
package ecc_pkg;

  localparam int ECC_DATA_W = 64;
  localparam int ECC_CHK_W  = 8;
  localparam int ECC_ADDR_W = 14;

  localparam int ECC_MAX_DW = 256;
  localparam int ECC_MAX_CW = 10;

  // Log entry in the default configuration.
  typedef struct packed {
    logic [ECC_ADDR_W-1:0] addr;
    logic [ECC_CHK_W-1:0]  syndrome;
    logic                  dbl;
  } ecc_log_t;

  function automatic bit ecc_is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  function automatic int ecc_data_pos(input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p < ECC_MAX_DW + ECC_MAX_CW; p++) begin
      if (!ecc_is_pow2(p) && pos == 0) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  function automatic int ecc_pos_data(input int pos);
    int cnt;
    if (pos < 1 || ecc_is_pow2(pos)) return -1;
    cnt = 0;
    for (int q = 1; q < ECC_MAX_DW + ECC_MAX_CW; q++)
      if (q < pos && !ecc_is_pow2(q)) cnt++;
    return cnt;
  endfunction

  // Single linear walk over the codeword: j tracks the data index that
  // occupies each non-power-of-two position.
  function automatic logic [ECC_MAX_DW-1:0] ecc_mask(input int bit_i, input int dw);
    logic [ECC_MAX_DW-1:0] m;
    int j;
    m = '0;
    j = 0;
    for (int p = 1; p < ECC_MAX_DW + ECC_MAX_CW; p++) begin
      if (!ecc_is_pow2(p)) begin
        if (j < dw && p[bit_i]) m[j] = 1'b1;
        j++;
      end
    end
    return m;
  endfunction

  function automatic logic [ECC_MAX_CW-1:0] ecc_chk(input logic [ECC_MAX_DW-1:0] data,
                                                    input int dw = ECC_DATA_W,
                                                    input int cw = ECC_CHK_W);
    logic [ECC_MAX_CW-1:0] c;
    logic par;
    int j;
    c = '0;
    j = 0;
    for (int p = 1; p < ECC_MAX_DW + ECC_MAX_CW; p++) begin
      if (!ecc_is_pow2(p)) begin
        if (j < dw) begin
          for (int i = 0; i < ECC_MAX_CW - 1; i++)
            if (i < cw - 1 && p[i] && data[j]) c[i] = ~c[i];
        end
        j++;
      end
    end
    par = 1'b0;
    for (int i = 0; i < ECC_MAX_CW - 1; i++)
      if (i < cw - 1) par = par ^ c[i];
    for (int k = 0; k < ECC_MAX_DW; k++)
      if (k < dw) par = par ^ data[k];
    c[cw-1] = par;
    return c;
  endfunction

endpackage

// File: rtl/ecc_check_log_if.sv
// ecc_check_log_if: SRAM read side, corrected-data output and error-log port
// of ecc_check_log bundled together.
//   slave  : the checker (consumes read/SRAM/control, drives out_* / log_*)
//   master : the environment (SRAM + consumer)
// cnt_single/cnt_double exist only when ECC_ERR_CNT_EN is defined.
interface ecc_check_log_if
  import ecc_pkg::*;
#(
  parameter int DATA_W = ECC_DATA_W,
  parameter int CHK_W  = ECC_CHK_W,
  parameter int ADDR_W = ECC_ADDR_W
) ();
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] sram_data;
  logic [CHK_W-1:0]  sram_chk;
  logic              clr;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_err_single;
  logic              out_err_double;
  logic              log_valid;
  logic              log_pop;
  logic [ADDR_W-1:0] log_addr;
  logic [CHK_W-1:0]  log_syndrome;
  logic              log_double;
  logic              log_overflow;
`ifdef ECC_ERR_CNT_EN
  logic [15:0]       cnt_single;
  logic [15:0]       cnt_double;
`endif

  modport slave (
    input  rd_en, rd_addr, sram_data, sram_chk, clr, log_pop,
    output out_valid, out_addr, out_data, out_err_single, out_err_double,
           log_valid, log_addr, log_syndrome, log_double, log_overflow
`ifdef ECC_ERR_CNT_EN
    , output cnt_single, cnt_double
`endif
  );

  modport master (
    output rd_en, rd_addr, sram_data, sram_chk, clr, log_pop,
    input  out_valid, out_addr, out_data, out_err_single, out_err_double,
           log_valid, log_addr, log_syndrome, log_double, log_overflow
`ifdef ECC_ERR_CNT_EN
    , input cnt_single, cnt_double
`endif
  );
endinterface

// File: rtl/ecc_check_log_fifo.sv
// ecc_log_fifo: DEPTH-entry synchronous FIFO holding error-log entries.
//   gclk/grst_n  clock, async active-low reset
//   push/din     write request (dropped when full unless a pop lands too)
//   pop          remove head, ignored when empty
//   clr          synchronous flush; beats push/pop in the same cycle
//   dout         head entry, zero while empty
//   full/empty   occupancy flags
//   overflow     sticky, set when a push was dropped
module ecc_log_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         clr,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wr, r_rd;
  logic [W-1:0] r_mem [DEPTH];
  logic         r_ovf;
  logic         w_do_pop, w_do_push;

  assign empty = (r_wr == r_rd);
  assign full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);

  // A pop on a full FIFO frees the slot the concurrent push needs.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      if (push && !w_do_push) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge gclk)
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= din;

  assign dout     = empty ? '0 : r_mem[r_rd[AW-1:0]];
  assign overflow = r_ovf;
endmodule

// File: rtl/ecc_check_log.sv
// ecc_check_log: SECDED read-check pipeline with error log.
//   CLK, RESET_N   clock, async active-low reset
//   bus (slave)    rd_en/rd_addr, sram_data/sram_chk (RD_LAT after rd_en),
//                  clr, out_* corrected word, log_* FIFO head + pop, overflow
// Pipeline: RD_LAT-deep address/valid delay -> stage 1 (aligned data + check
// bits, syndrome decode) -> stage 2 (corrected output, log push).
// Latency rd_en -> out_valid is RD_LAT+2; one read per cycle.
// Optional: ECC_ERR_CNT_EN adds saturating 16-bit single/double counters.
// RD_LAT must be 1..4, LOG_DEPTH a power of two >= 2, and
// 2^(CHK_W-1) >= DATA_W+CHK_W.
module ecc_check_log
  import ecc_pkg::*;
#(
  parameter int DATA_W    = ECC_DATA_W,
  parameter int CHK_W     = ECC_CHK_W,
  parameter int ADDR_W    = ECC_ADDR_W,
  parameter int RD_LAT    = 1,
  parameter int LOG_DEPTH = 4
) (
  input logic            CLK,
  input logic            RESET_N,
  ecc_check_log_if.slave bus
);
  localparam int SW       = CHK_W - 1;
  localparam int LAST_POS = DATA_W + CHK_W - 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [CHK_W-1:0]  syndrome;
    logic              dbl;
  } log_t;

  // ---- read address/valid delay to meet SRAM data ----
  logic [RD_LAT-1:0]             r_vld_pipe;
  logic [RD_LAT-1:0][ADDR_W-1:0] r_addr_pipe;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_vld_pipe  <= '0;
      r_addr_pipe <= '0;
    end else begin
      r_vld_pipe[0]  <= bus.rd_en;
      r_addr_pipe[0] <= bus.rd_addr;
      for (int k = RD_LAT - 1; k > 0; k--) begin
        r_vld_pipe[k]  <= r_vld_pipe[k-1];
        r_addr_pipe[k] <= r_addr_pipe[k-1];
      end
    end
  end

  // ---- stage 1 ----
  logic              r_s1_vld;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [DATA_W-1:0] r_s1_data;
  logic [CHK_W-1:0]  r_s1_chk;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_s1_vld  <= 1'b0;
      r_s1_addr <= '0;
      r_s1_data <= '0;
      r_s1_chk  <= '0;
    end else begin
      r_s1_vld  <= r_vld_pipe[RD_LAT-1];
      r_s1_addr <= r_addr_pipe[RD_LAT-1];
      r_s1_data <= bus.sram_data;
      r_s1_chk  <= bus.sram_chk;
    end
  end

  // ---- decode ----
  logic [SW-1:0]     w_syn;
  logic              w_p;
  logic [DATA_W-1:0] w_flip;
  logic              w_beyond, w_sgl, w_dbl;
  logic [DATA_W-1:0] w_cor;

  // Syndrome bit i = stored check bit i vs. parity over its coverage mask.
  for (genvar i = 0; i < SW; i++) begin : g_syn
    localparam logic [ECC_MAX_DW-1:0] MASK = ecc_mask(i, DATA_W);
    assign w_syn[i] = r_s1_chk[i] ^ (^(r_s1_data & MASK[DATA_W-1:0]));
  end

  // Overall parity covers every stored bit, so a clean word XORs to zero.
  assign w_p = ^{r_s1_data, r_s1_chk};

  // Only an odd error count may correct; check-bit positions never match here.
  for (genvar j = 0; j < DATA_W; j++) begin : g_flip
    localparam logic [SW-1:0] POS = SW'(ecc_data_pos(j));
    assign w_flip[j] = w_p && (w_syn == POS);
  end

  // Odd error count pointing outside the codeword cannot be a single error.
  assign w_beyond = (32'(w_syn) > 32'(LAST_POS));
  assign w_sgl    = r_s1_vld && w_p && !w_beyond;
  assign w_dbl    = r_s1_vld && ((!w_p && (|w_syn)) || (w_p && w_beyond));
  assign w_cor    = r_s1_data ^ w_flip;

  // ---- stage 2 ----
  logic              r_out_vld, r_out_sgl, r_out_dbl;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_out_vld  <= 1'b0;
      r_out_sgl  <= 1'b0;
      r_out_dbl  <= 1'b0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      r_out_vld <= r_s1_vld;
      r_out_sgl <= w_sgl;
      r_out_dbl <= w_dbl;
      if (r_s1_vld) begin
        r_out_addr <= r_s1_addr;
        r_out_data <= w_cor;
      end
    end
  end

  assign bus.out_valid      = r_out_vld;
  assign bus.out_addr       = r_out_addr;
  assign bus.out_data       = r_out_data;
  assign bus.out_err_single = r_out_sgl;
  assign bus.out_err_double = r_out_dbl;

  // ---- error log: pushed on the stage-2 edge so it shows with out_valid ----
  log_t w_log_in, w_log_head;
  logic w_log_full, w_log_empty, w_log_ovf;

  assign w_log_in = '{addr: r_s1_addr, syndrome: {w_p, w_syn}, dbl: w_dbl};

  ecc_log_fifo #(
    .W     ($bits(log_t)),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .gclk     (CLK),
    .grst_n   (RESET_N),
    .push     (w_sgl || w_dbl),
    .din      (w_log_in),
    .pop      (bus.log_pop),
    .clr      (bus.clr),
    .dout     (w_log_head),
    .full     (w_log_full),
    .empty    (w_log_empty),
    .overflow (w_log_ovf)
  );

  assign bus.log_valid    = !w_log_empty;
  assign bus.log_addr     = w_log_head.addr;
  assign bus.log_syndrome = w_log_head.syndrome;
  assign bus.log_double   = w_log_head.dbl;
  assign bus.log_overflow = w_log_ovf;

  // Occupancy is implicit in log_valid; full is only needed inside the FIFO.
  logic w_unused_full;
  assign w_unused_full = w_log_full;

`ifdef ECC_ERR_CNT_EN
  logic [15:0] r_cnt_sgl, r_cnt_dbl;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt_sgl <= '0;
      r_cnt_dbl <= '0;
    end else if (bus.clr) begin
      r_cnt_sgl <= '0;
      r_cnt_dbl <= '0;
    end else begin
      if (w_sgl && r_cnt_sgl != 16'hFFFF) r_cnt_sgl <= r_cnt_sgl + 16'd1;
      if (w_dbl && r_cnt_dbl != 16'hFFFF) r_cnt_dbl <= r_cnt_dbl + 16'd1;
    end
  end

  assign bus.cnt_single = r_cnt_sgl;
  assign bus.cnt_double = r_cnt_dbl;
`endif
endmodule

// File: tb/tb_ecc_check_log.sv
// Scoreboard bench for ecc_check_log (default parameters, RD_LAT=1,
// LOG_DEPTH=4). Reads push expected words into sb; a negedge monitor pops
// and compares whenever out_valid is high. Log contents are checked directly.
module tb_ecc_check_log;
  import ecc_pkg::*;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  ecc_check_log_if #(.DATA_W(64), .CHK_W(8), .ADDR_W(14)) bus ();

  ecc_check_log #(
    .DATA_W(64), .CHK_W(8), .ADDR_W(14), .RD_LAT(1), .LOG_DEPTH(4)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  typedef struct {
    logic [13:0] addr;
    logic [63:0] data;
    logic        sgl;
    logic        dbl;
    int          due;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_vld = 0;
  int cyc = 0;

  logic [63:0] mem_d [64];
  logic [7:0]  mem_c [64];

  localparam logic [63:0] D = 64'h0123_4567_89AB_CDEF;
  logic [7:0] C;

  always @(posedge CLK) cyc <= cyc + 1;

  // SRAM model, read latency 1
  always @(posedge CLK)
    if (bus.rd_en) begin
      bus.sram_data <= mem_d[bus.rd_addr[5:0]];
      bus.sram_chk  <= mem_c[bus.rd_addr[5:0]];
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (bus.out_valid) begin
      n_vld++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got addr %0h expected no output", bus.out_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_latency", 64'(cyc), 64'(e.due));
        chk("out_addr", 64'(bus.out_addr), 64'(e.addr));
        chk("out_data", bus.out_data, e.data);
        chk("out_err_single", 64'(bus.out_err_single), 64'(e.sgl));
        chk("out_err_double", 64'(bus.out_err_double), 64'(e.dbl));
      end
    end else if (RESET_N) begin
      chk("idle_flags", 64'({bus.out_err_single, bus.out_err_double}), 64'd0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [63:0] d, input logic [7:0] c);
    mem_d[a[5:0]] = d;
    mem_c[a[5:0]] = c;
  endtask

  task automatic rd(input logic [13:0] a, input logic [63:0] ed, input logic es, input logic edb);
    exp_t e;
    e.addr = a; e.data = ed; e.sgl = es; e.dbl = edb; e.due = cyc + 3;
    sb.push_back(e);
    bus.rd_en = 1'b1;
    bus.rd_addr = a;
    @(posedge CLK);
    #1 bus.rd_en = 1'b0;
  endtask

  task automatic rd_raw(input logic [13:0] a);
    bus.rd_en = 1'b1;
    bus.rd_addr = a;
    @(posedge CLK);
    #1 bus.rd_en = 1'b0;
  endtask

  task automatic check_log(input string nm, input logic v, input logic [13:0] a,
                           input logic [7:0] s, input logic d);
    chk({nm, "_valid"}, 64'(bus.log_valid), 64'(v));
    if (v) begin
      chk({nm, "_addr"}, 64'(bus.log_addr), 64'(a));
      chk({nm, "_syn"}, 64'(bus.log_syndrome), 64'(s));
      chk({nm, "_dbl"}, 64'(bus.log_double), 64'(d));
    end
  endtask

  task automatic pop();
    bus.log_pop = 1'b1;
    @(posedge CLK);
    #1 bus.log_pop = 1'b0;
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    @(posedge CLK);
    #1 bus.clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ECC_MAX_CW-1:0] c10;
    ecc_log_t le;
    int nv0;
    c10 = ecc_chk(ECC_MAX_DW'(D));
    C = c10[7:0];

    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.clr = 1'b0; bus.log_pop = 1'b0;
    RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_addr", 64'(bus.out_addr), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_out_flags", 64'({bus.out_err_single, bus.out_err_double}), 64'd0);
    le = '{addr: bus.log_addr, syndrome: bus.log_syndrome, dbl: bus.log_double};
    chk("rst_log_entry", 64'(le), 64'd0);
    chk("rst_log_valid", 64'(bus.log_valid), 64'd0);
    chk("rst_log_overflow", 64'(bus.log_overflow), 64'd0);
`ifdef ECC_ERR_CNT_EN
    chk("rst_cnt", 64'({bus.cnt_single, bus.cnt_double}), 64'd0);
`endif
    @(posedge CLK);
    #1 RESET_N = 1'b1;
    cycles(1);

    // clean read
    wr(14'h0005, D, C);
    rd(14'h0005, D, 1'b0, 1'b0);
    cycles(4);
    check_log("clean_log", 1'b0, '0, '0, 1'b0);

    // single data error, data[5] -> position 10
    wr(14'h0005, D ^ 64'h20, C);
    rd(14'h0005, D, 1'b1, 1'b0);
    cycles(4);
    check_log("sgl_log", 1'b1, 14'h0005, 8'h8A, 1'b0);
    pop();
    check_log("sgl_pop", 1'b0, '0, '0, 1'b0);

    // double error, data[0] and data[1]
    wr(14'h0005, D ^ 64'h3, C);
    rd(14'h0005, D ^ 64'h3, 1'b0, 1'b1);
    cycles(4);
    check_log("dbl_log", 1'b1, 14'h0005, 8'h06, 1'b1);
    pop();

    // check bit 0 flipped: syndrome 1 is a check position, data untouched
    wr(14'h0006, D, C ^ 8'h01);
    rd(14'h0006, D, 1'b1, 1'b0);
    // overall parity bit flipped only
    wr(14'h0007, D, C ^ 8'h80);
    rd(14'h0007, D, 1'b1, 1'b0);
    // three flips (positions 3,10,65) -> syndrome 72, outside the codeword
    wr(14'h0008, D ^ 64'h0200_0000_0000_0021, C);
    rd(14'h0008, D ^ 64'h0200_0000_0000_0021, 1'b0, 1'b1);
    cycles(4);
    check_log("chk0_log", 1'b1, 14'h0006, 8'h81, 1'b0);
    pop();
    check_log("par_log", 1'b1, 14'h0007, 8'h80, 1'b0);
    pop();
    check_log("beyond_log", 1'b1, 14'h0008, 8'hC8, 1'b1);
    pop();
    check_log("drained", 1'b0, '0, '0, 1'b0);

    // overflow: 5 single errors into a 4-deep log
    do_clr();
    for (int i = 0; i < 5; i++) wr(14'(16 + i), D ^ 64'h20, C);
    for (int i = 0; i < 5; i++) rd(14'(16 + i), D, 1'b1, 1'b0);
    cycles(5);
    chk("ovf_set", 64'(bus.log_overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check_log("ovf_log", 1'b1, 14'(16 + i), 8'h8A, 1'b0);
      pop();
    end
    check_log("ovf_empty", 1'b0, '0, '0, 1'b0);
    chk("ovf_sticky", 64'(bus.log_overflow), 64'd1);
    do_clr();
    chk("ovf_clr", 64'(bus.log_overflow), 64'd0);

    // full log: push and pop on the same edge
    for (int i = 0; i < 5; i++) wr(14'(32 + i), D ^ 64'h20, C);
    for (int i = 0; i < 4; i++) rd(14'(32 + i), D, 1'b1, 1'b0);
    cycles(4);
    rd(14'd36, D, 1'b1, 1'b0);
    @(posedge CLK);
    #1 bus.log_pop = 1'b1;
    @(posedge CLK);
    #1 bus.log_pop = 1'b0;
    cycles(2);
    chk("pp_ovf", 64'(bus.log_overflow), 64'd0);
    for (int i = 1; i < 5; i++) begin
      check_log("pp_log", 1'b1, 14'(32 + i), 8'h8A, 1'b0);
      pop();
    end
    check_log("pp_empty", 1'b0, '0, '0, 1'b0);

    // reset with two reads in flight
    wr(14'd40, D, C);
    nv0 = n_vld;
    rd_raw(14'd40);
    rd_raw(14'd40);
    RESET_N = 1'b0;
    cycles(2);
    RESET_N = 1'b1;
    cycles(8);
    chk("rst_no_stale", 64'(n_vld - nv0), 64'd0);

`ifdef ECC_ERR_CNT_EN
    do_clr();
    for (int i = 0; i < 3; i++) wr(14'(48 + i), D ^ 64'h20, C);
    wr(14'd51, D ^ 64'h3, C);
    for (int i = 0; i < 3; i++) rd(14'(48 + i), D, 1'b1, 1'b0);
    rd(14'd51, D ^ 64'h3, 1'b0, 1'b1);
    cycles(4);
    chk("cnt_single", 64'(bus.cnt_single), 64'd3);
    chk("cnt_double", 64'(bus.cnt_double), 64'd1);
    do_clr();
    chk("cnt_clr", 64'({bus.cnt_single, bus.cnt_double}), 64'd0);
    check_log("cnt_log_clr", 1'b0, '0, '0, 1'b0);
`endif

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge CLK);
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
